video_stream_ctrl: RTL and testbench

- Pixel-clock-domain controller that qualifies the incoming VSYNC/HSYNC/DE stream before it enters the edge-detection datapath.
- Locks to a frame of fixed geometry and sequences a 3-line rotating line buffer: write select, write address and write enable.
- Raises the processing-window enable once enough lines are buffered.
- Issues the frame-start pulse that re-aligns the output video timing generator (its I_VRST).

---
 rtl/video_stream_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_video_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_ctrl.sv
// Pixel-clock stream qualifier: locks to fixed-geometry VSYNC/HSYNC/DE video,
// sequences a 3-line rotating line buffer and issues the timing-generator
// frame-start pulse.
module video_stream_ctrl #(
  parameter int unsigned HACT        = 640,
  parameter int unsigned VACT        = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             I_PCLK,
  input  logic             I_RST_N,
  input  logic             I_EN,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  output logic             O_LOCKED,
  output logic             O_LB_WE,
  output logic [1:0]       O_LB_WSEL,
  output logic [CNT_W-1:0] O_LB_WADDR,
  output logic             O_PROC_EN,
  output logic             O_VRST,
  output logic             O_ERR
);

  localparam logic [CNT_W-1:0] HACT_C   = CNT_W'(HACT);
  localparam logic [CNT_W-1:0] VACT_C   = CNT_W'(VACT);
  localparam logic [CNT_W-1:0] LINE_MAX = '1;
  localparam logic [CNT_W-1:0] TWO_C    = CNT_W'(2);
  localparam logic [3:0]       LOCK_C   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;

  logic             vs_q, hs_q, de_q;
  logic             vs_rise, de_rise, de_fall;
  logic [CNT_W-1:0] pix_cnt_q, pix_cur;
  logic             ovf_q, ovf_cur;
  logic [CNT_W-1:0] line_cnt_q, line_cur, line_end;
  logic             bad_seen_q;
  logic             line_bad, frame_bad, lose_lock, lock_act;

  logic             locked_d, we_d, proc_d, vrst_d, err_d;
  logic [1:0]       wsel_d;
  logic [CNT_W-1:0] waddr_d;

  // HSYNC is only monitored; the registered copy feeds no control logic
  logic unused_hs;
  assign unused_hs = hs_q;

  // Single input register stage for edge decoding
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= I_VSYNC;
      hs_q <= I_HSYNC;
      de_q <= I_DE;
    end
  end

  assign vs_rise = I_VSYNC & ~vs_q;
  assign de_rise = I_DE & ~de_q;
  assign de_fall = ~I_DE & de_q;

  // Current-cycle views: a rising edge restarts the count in the same cycle
  assign pix_cur  = de_rise ? '0 : pix_cnt_q;
  assign ovf_cur  = de_rise ? 1'b0 : ovf_q;
  assign line_cur = vs_rise ? '0 : line_cnt_q;
  assign line_end = line_cnt_q + CNT_W'(de_fall);

  // Geometry checks; a line ending on the same cycle as VSYNC still counts
  assign line_bad  = de_fall & ((pix_cnt_q != HACT_C) | ovf_q);
  assign frame_bad = (line_end != VACT_C) | bad_seen_q | line_bad | I_DE;
  assign lose_lock = line_bad | (vs_rise & frame_bad);
  assign lock_act  = (state_q == ST_LOCKED) & I_EN;

  // Pixel/line counters and per-frame bad-line memory
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      line_cnt_q <= '0;
      bad_seen_q <= 1'b0;
    end else begin
      pix_cnt_q <= (I_DE && (pix_cur != HACT_C)) ? pix_cur + CNT_W'(1) : pix_cur;
      ovf_q     <= ovf_cur | (I_DE & (pix_cur == HACT_C));
      if (vs_rise) begin
        line_cnt_q <= '0;
        bad_seen_q <= 1'b0;
      end else begin
        if (de_fall && (line_cnt_q != LINE_MAX)) begin
          line_cnt_q <= line_cnt_q + CNT_W'(1);
        end
        bad_seen_q <= bad_seen_q | line_bad;
      end
    end
  end

  // FSM state register
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= ST_IDLE;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // FSM next-state and good-frame counting
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    if (!I_EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (vs_rise) begin
            good_cnt_d = '0;
            state_d    = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (vs_rise) begin
            if (frame_bad) begin
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
              if (good_cnt_d == LOCK_C) begin
                state_d = ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (lose_lock) begin
            state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    we_d     = lock_act & I_DE & (pix_cur < HACT_C);
    waddr_d  = we_d ? pix_cur : '0;
    proc_d   = we_d & (line_cur >= TWO_C);
    vrst_d   = vs_rise & (state_d == ST_LOCKED);
    err_d    = O_ERR | (lock_act & lose_lock);
    wsel_d   = O_LB_WSEL;
    if ((state_d != ST_LOCKED) || vs_rise) begin
      wsel_d = 2'd0;
    end else if (de_fall) begin
      wsel_d = (O_LB_WSEL == 2'd2) ? 2'd0 : O_LB_WSEL + 2'd1;
    end
  end

  // Output register stage
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_LOCKED   <= 1'b0;
      O_LB_WE    <= 1'b0;
      O_LB_WSEL  <= 2'd0;
      O_LB_WADDR <= '0;
      O_PROC_EN  <= 1'b0;
      O_VRST     <= 1'b0;
      O_ERR      <= 1'b0;
    end else begin
      O_LOCKED   <= locked_d;
      O_LB_WE    <= we_d;
      O_LB_WSEL  <= wsel_d;
      O_LB_WADDR <= waddr_d;
      O_PROC_EN  <= proc_d;
      O_VRST     <= vrst_d;
      O_ERR      <= err_d;
    end
  end

endmodule

// File: tb/tb_video_stream_ctrl.sv
// Directed bench for video_stream_ctrl with an 8x4 frame geometry.
`timescale 1ns/1ps
module tb_video_stream_ctrl;

  localparam int unsigned CNT_W = 12;

  logic             I_PCLK, I_RST_N, I_EN, I_VSYNC, I_HSYNC, I_DE;
  logic             O_LOCKED, O_LB_WE, O_PROC_EN, O_VRST, O_ERR;
  logic [1:0]       O_LB_WSEL;
  logic [CNT_W-1:0] O_LB_WADDR;

  video_stream_ctrl #(
    .HACT(8), .VACT(4), .LOCK_FRAMES(2), .CNT_W(CNT_W)
  ) dut (
    .I_PCLK(I_PCLK), .I_RST_N(I_RST_N), .I_EN(I_EN), .I_VSYNC(I_VSYNC),
    .I_HSYNC(I_HSYNC), .I_DE(I_DE), .O_LOCKED(O_LOCKED), .O_LB_WE(O_LB_WE),
    .O_LB_WSEL(O_LB_WSEL), .O_LB_WADDR(O_LB_WADDR), .O_PROC_EN(O_PROC_EN),
    .O_VRST(O_VRST), .O_ERR(O_ERR)
  );

  initial I_PCLK = 1'b0;
  always #5 I_PCLK = ~I_PCLK;

  int tests = 0;
  int fails = 0;

  // Observation accumulators, cleared per line / per vsync pulse
  int               we_n, proc_n, vrst_n, addr_err, wsel_seen;
  logic [CNT_W-1:0] exp_addr;
  logic             lk_at_vs, lk_fall, err_fall;

  typedef struct {
    logic vs;
    int   exp_vrst;
    int   de_len;
    int   exp_we;
    int   exp_proc;
    int   exp_wsel;
    logic exp_lk;
    logic exp_err;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    we_n = 0; proc_n = 0; vrst_n = 0; addr_err = 0; wsel_seen = 0;
    exp_addr = '0;
  endtask

  // Drive one cycle of inputs, then sample registered outputs 1 ns after the edge
  task automatic step(input logic vs, input logic de);
    I_VSYNC = vs;
    I_DE    = de;
    I_HSYNC = ~de;
    @(posedge I_PCLK);
    #1;
    if (O_LB_WE) begin
      we_n++;
      if (O_LB_WADDR != exp_addr) addr_err++;
      exp_addr  = exp_addr + 1'b1;
      wsel_seen = int'(O_LB_WSEL);
    end
    if (O_PROC_EN) proc_n++;
    if (O_VRST) vrst_n++;
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0);
    lk_at_vs = O_LOCKED;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic run_line(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    lk_fall  = O_LOCKED;
    err_fall = O_ERR;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic frame4();
    for (int k = 0; k < 4; k++) run_line(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 0, 8,  8, 0, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 0, 8,  8, 0, 1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 0, 8,  8, 8, 2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 0, 8,  8, 8, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1, 8,  8, 0, 0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 0, 8,  8, 0, 1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 0, 7,  7, 7, 2, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 0, 8,  0, 0, 0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1, 8,  8, 0, 0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 0, 8,  8, 0, 1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 0, 10, 8, 8, 2, 1'b0, 1'b1};

    I_RST_N = 1'b0; I_EN = 1'b0; I_VSYNC = 1'b0; I_HSYNC = 1'b0; I_DE = 1'b0;
    clr();
    repeat (3) @(posedge I_PCLK);
    #1;
    chk("reset_outputs", {O_LOCKED, O_LB_WE, O_LB_WSEL, O_LB_WADDR, O_PROC_EN, O_VRST, O_ERR}, '0);
    I_RST_N = 1'b1;
    I_EN    = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Initial lock: SEARCH exit, then two good frames
    vs_pulse();
    chk("lock_vs1", lk_at_vs, 1'b0);
    frame4();
    vs_pulse();
    chk("lock_vs2", lk_at_vs, 1'b0);
    frame4();
    chk("lock_before_vs3", O_LOCKED, 1'b0);
    step(1'b1, 1'b0);
    chk("lock_at_vs3", O_LOCKED, 1'b1);
    chk("vrst_at_vs3", O_VRST, 1'b1);
    step(1'b1, 1'b0);
    chk("vrst_one_cycle", O_VRST, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Locked write sequencing, short line, re-lock, overlong line
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].vs) begin
        clr();
        vs_pulse();
        chk($sformatf("row%0d_vrst", i), vrst_n, tbl[i].exp_vrst);
      end
      clr();
      run_line(tbl[i].de_len);
      chk($sformatf("row%0d_we_cycles", i), we_n, tbl[i].exp_we);
      chk($sformatf("row%0d_proc_cycles", i), proc_n, tbl[i].exp_proc);
      chk($sformatf("row%0d_addr_seq_errs", i), addr_err, 0);
      if (tbl[i].exp_we > 0) chk($sformatf("row%0d_wsel", i), wsel_seen, tbl[i].exp_wsel);
      chk($sformatf("row%0d_locked", i), lk_fall, tbl[i].exp_lk);
      chk($sformatf("row%0d_err", i), err_fall, tbl[i].exp_err);
    end

    // Finish the broken frame, re-lock, then a 5-line frame drops lock silently
    run_line(8);
    vs_pulse();
    frame4();
    vs_pulse();
    chk("relock_a_vs2", lk_at_vs, 1'b0);
    frame4();
    clr();
    vs_pulse();
    chk("relock_a_vs3", lk_at_vs, 1'b1);
    chk("relock_a_vrst", vrst_n, 1);
    frame4();
    run_line(8);
    clr();
    vs_pulse();
    chk("long_frame_vrst", vrst_n, 0);
    chk("long_frame_locked", O_LOCKED, 1'b0);
    chk("long_frame_err", O_ERR, 1'b1);

    // VSYNC rising during DE in MEASURE costs one frame
    vs_pulse();
    frame4();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) run_line(8);
    vs_pulse();
    chk("illegal_sync_delays_lock", lk_at_vs, 1'b0);
    frame4();
    vs_pulse();
    chk("illegal_sync_then_lock", lk_at_vs, 1'b1);

    // Enable dropped mid-line
    run_line(8);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    chk("en_pre_we", O_LB_WE, 1'b1);
    chk("en_pre_wsel", O_LB_WSEL, 2'd1);
    I_EN = 1'b0;
    step(1'b0, 1'b1);
    chk("en_off_outputs", {O_LOCKED, O_LB_WE, O_LB_WSEL, O_LB_WADDR, O_PROC_EN, O_VRST}, '0);
    chk("en_off_err_holds", O_ERR, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    I_EN = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Re-lock, then asynchronous reset mid-line
    vs_pulse();
    frame4();
    vs_pulse();
    frame4();
    vs_pulse();
    chk("rst_pre_locked", lk_at_vs, 1'b1);
    run_line(8);
    run_line(8);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    chk("rst_pre_err", O_ERR, 1'b1);
    #2;
    I_RST_N = 1'b0;
    #1;
    chk("async_reset_outputs", {O_LOCKED, O_LB_WE, O_LB_WSEL, O_LB_WADDR, O_PROC_EN, O_VRST, O_ERR}, '0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    I_RST_N = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    vs_pulse();
    chk("post_rst_vs1", lk_at_vs, 1'b0);
    frame4();
    vs_pulse();
    chk("post_rst_vs2", lk_at_vs, 1'b0);
    frame4();
    clr();
    vs_pulse();
    chk("post_rst_vs3_locked", lk_at_vs, 1'b1);
    chk("post_rst_vrst", vrst_n, 1);
    chk("post_rst_err_clear", O_ERR, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
